// File: rtl/sr_write_seq_pkg.sv
// Shared types and constants for the SR latch-bank write sequencer.
package sr_write_seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_PULSE,
        ST_GAP0,
        ST_SET_PULSE,
        ST_GAP1,
        ST_CHECK
    } state_t;

    // Bits needed to hold max(a,b) without wrapping; never narrower than 1.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_latch.sv
// Behavioural model of one external SR latch cell: s sets, r clears, s=r=0 holds.
module sr_latch (
    input  logic i_s,
    input  logic i_r,
    output logic o_q
);

    always_latch begin
        if (i_s || i_r) begin
            o_q <= i_s;
        end
    end

endmodule

// File: rtl/sr_write_seq_phase_cnt.sv
// Phase down-counter shared by every timed state of the write sequencer.
module phase_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sr_write_seq.sv
// Write sequencer for a bank of external SR latches: clear pulse, gap, set
// pulse, gap, then readback compare.
//
// state        | meaning
// -------------+--------------------------------------------------
// ST_IDLE      | waiting for wr_en; captures wr_data on request
// ST_RST_PULSE | r = ~data_q for PULSE_CYCLES
// ST_GAP0      | s = r = 0 for GAP_CYCLES
// ST_SET_PULSE | s = data_q for PULSE_CYCLES
// ST_GAP1      | s = r = 0 for GAP_CYCLES
// ST_CHECK     | one cycle: sample q, pulse done, flag mismatch
module sr_write_seq
    import sr_write_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] s,
    output logic [DATA_W-1:0] r,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data
);

    localparam int CNT_W = cnt_width(PULSE_CYCLES, GAP_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] r_s;
    logic [DATA_W-1:0] r_r;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rd_data;

    logic              w_load;
    logic [CNT_W-1:0]  w_load_val;
    logic              w_dec;
    logic              w_zero;

    phase_cnt #(.W(CNT_W)) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Counter is loaded with (duration-1) on entry, so each timed state
    // leaves on the cycle it reads zero.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wr_en) begin
                    w_load     = 1'b1;
                    w_load_val = PULSE_LD;
                end
            end
            ST_RST_PULSE, ST_SET_PULSE: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = GAP_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP0: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = PULSE_LD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP1: begin
                w_dec = ~w_zero;
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_data_q  <= '0;
            r_s       <= '0;
            r_r       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_en) begin
                        r_data_q <= wr_data;
                        r_r      <= ~wr_data;
                        r_s      <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_RST_PULSE;
                    end
                end
                ST_RST_PULSE: begin
                    if (w_zero) begin
                        r_r     <= '0;
                        r_state <= ST_GAP0;
                    end
                end
                ST_GAP0: begin
                    if (w_zero) begin
                        r_s     <= r_data_q;
                        r_state <= ST_SET_PULSE;
                    end
                end
                ST_SET_PULSE: begin
                    if (w_zero) begin
                        r_s     <= '0;
                        r_state <= ST_GAP1;
                    end
                end
                ST_GAP1: begin
                    if (w_zero) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_rd_data <= q;
                    r_done    <= 1'b1;
                    r_err     <= (q != r_data_q);
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_s     <= '0;
                    r_r     <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s       = r_s;
    assign r       = r_r;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign rd_data = r_rd_data;

endmodule

// File: tb/tb_sr_write_seq.sv
// Scoreboard bench for sr_write_seq driving four external sr_latch cells.
module tb_sr_write_seq;

    localparam int P   = 4;
    localparam int G   = 1;
    localparam int LAT = 2*P + 2*G + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic [3:0] stuck = 4'h0;
    logic [3:0] q, s, r, rd_data;
    logic       busy, done, err;
    logic [3:0] w_latch_q;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [3:0] rd;
        logic       err;
        int         due;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sr_write_seq #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .q       (q),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rd_data (rd_data)
    );

    for (genvar i = 0; i < 4; i++) begin : g_latch
        sr_latch u_latch (.i_s(s[i]), .i_r(r[i]), .o_q(w_latch_q[i]));
    end

    // Stuck-at-0 injection on the readback path only.
    assign q = w_latch_q & ~stuck;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("s_and_r_overlap", int'(s & r), 0);
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("rd_data", rd_data, e.rd);
                    chk("err_at_done", err, e.err);
                    chk("done_cycle", cyc, e.due);
                end
            end else begin
                chk("err_without_done", err, 0);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the CHECK cycle.
    task automatic write_chk(input logic [3:0] d, input logic [3:0] exp_rd,
                             input logic exp_err, input bit hold,
                             input logic [3:0] late_data);
        logic [3:0] exp_r, exp_s;
        wr_en   = 1'b1;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
        sb.push_back('{exp_rd, exp_err, cyc + LAT});
        if (!hold) wr_en = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            if (k > 0) @(negedge clk);
            if (hold && k == 5) wr_data = late_data;
            exp_r = (k < P) ? ~d : 4'h0;
            exp_s = (k >= P + G && k < 2*P + G) ? d : 4'h0;
            chk($sformatf("r_%0h_k%0d", d, k), r, exp_r);
            chk($sformatf("s_%0h_k%0d", d, k), s, exp_s);
            chk($sformatf("busy_%0h_k%0d", d, k), busy, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_s", s, 0);
        chk("rst_r", r, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);

        // First request right at reset release.
        rst = 1'b0;
        write_chk(4'hA, 4'hA, 1'b0, 1'b0, 4'h0);
        @(negedge clk);

        // Back-to-back: all set, then all clear.
        write_chk(4'hF, 4'hF, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        write_chk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0);
        @(negedge clk);

        // wr_en held through a write; new data only taken in the next IDLE.
        write_chk(4'h3, 4'h3, 1'b0, 1'b1, 4'hC);
        @(negedge clk);
        write_chk(4'hC, 4'hC, 1'b0, 1'b0, 4'h0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("rd_data_hold", rd_data, 4'hC);
        chk("idle_busy", busy, 0);

        // Abort during SET_PULSE of 4'h5: latch C -> 4 after clear -> 5 on set.
        wr_en   = 1'b1;
        wr_data = 4'h5;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_abort_s", s, 4'h5);
        rst = 1'b1;
        #1;
        chk("abort_s", s, 0);
        chk("abort_r", r, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd_data", rd_data, 0);
        chk("abort_q", q, 4'h5);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("retained_q", q, 4'h5);
        chk("post_abort_busy", busy, 0);

        // Readback of bit0 stuck at 0.
        stuck = 4'h1;
        write_chk(4'h1, 4'h0, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        stuck = 4'h0;

        repeat (2) @(negedge clk);
        chk("pending_done", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
